// File: rtl/diff_accum.sv
//------------------------------------------------------------------------------
// Module   : diff_accum
// Function : saturating signed accumulator of a fixed-length difference stream
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module diff_accum #(
  parameter int DATA_W = 16,
  parameter int ACC_W  = 24,
  parameter int LEN_W  = 10
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic [LEN_W-1:0]         len,
  input  logic signed [DATA_W-1:0] diff_in,
  input  logic                     diff_valid,
  output logic                     diff_ready,
  output logic signed [ACC_W-1:0]  sum_out,
  output logic                     sum_valid,
  output logic                     busy,
  output logic                     ovf
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic signed [ACC_W:0] c_acc_max = {2'b00, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W:0] c_acc_min = {2'b11, {(ACC_W-1){1'b0}}};

  state_t                  r_state;
  logic signed [ACC_W-1:0] r_acc;
  logic [LEN_W-1:0]        r_remaining;
  logic                    r_ovf;

  logic signed [ACC_W:0]   w_ext_diff;
  logic signed [ACC_W:0]   w_sum;
  logic                    w_pos_sat;
  logic                    w_neg_sat;
  logic                    w_transfer;

  // One guard bit above the accumulator makes both overflow directions visible.
  assign w_ext_diff = {{(ACC_W+1-DATA_W){diff_in[DATA_W-1]}}, diff_in};
  assign w_sum      = {r_acc[ACC_W-1], r_acc} + w_ext_diff;
  assign w_pos_sat  = (w_sum > c_acc_max);
  assign w_neg_sat  = (w_sum < c_acc_min);
  assign w_transfer = diff_valid && (r_state == ACCUM);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_acc       <= '0;
      r_remaining <= '0;
      r_ovf       <= 1'b0;
    end else begin
      case (r_state)
        IDLE, DONE: begin
          if (start) begin
            r_acc <= '0;
            r_ovf <= 1'b0;
            if (len == '0) begin
              r_remaining <= '0;
              r_state     <= DONE;
            end else begin
              r_remaining <= len;
              r_state     <= ACCUM;
            end
          end
        end
        ACCUM: begin
          if (w_transfer) begin
            if (w_pos_sat) begin
              r_acc <= c_acc_max[ACC_W-1:0];
              r_ovf <= 1'b1;
            end else if (w_neg_sat) begin
              r_acc <= c_acc_min[ACC_W-1:0];
              r_ovf <= 1'b1;
            end else begin
              r_acc <= w_sum[ACC_W-1:0];
            end
            r_remaining <= r_remaining - LEN_W'(1);
            if (r_remaining == LEN_W'(1)) begin
              r_state <= DONE;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Handshake and status decode from the state register alone.
  assign diff_ready = (r_state == ACCUM);
  assign busy       = (r_state == ACCUM);
  assign sum_valid  = (r_state == DONE);
  assign sum_out    = r_acc;
  assign ovf        = r_ovf;

endmodule

`default_nettype wire

// File: doc/diff_accum.md
DIFF_ACCUM -- requirements
Module: diff_accum

Interface
REQ-001 Parameter DATA_W, 16, width of the signed difference input; it equals the upstream subtractor output width.
REQ-002 Parameter ACC_W, 24, width of the signed accumulator and result.
REQ-003 Parameter LEN_W, 10, width of the sample-count input.
REQ-004 clk  input  1  single clock; all state changes on the rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset; the block has one clock, and rst_n is asserted asynchronously and deasserted synchronously.
REQ-006 start  input  1  one-cycle request to begin a new accumulation run.
REQ-007 len  input  LEN_W  number of differences to accumulate; sampled only when start is accepted.
REQ-008 diff_in  input  DATA_W  two's-complement difference (A-B) from the subtractor stage.
REQ-009 diff_valid  input  1  diff_in is valid this cycle.
REQ-010 diff_ready  output  1  block accepts diff_in this cycle.
REQ-011 sum_out  output  ACC_W  signed running/final sum.
REQ-012 sum_valid  output  1  sum_out holds the final result of a completed run.
REQ-013 busy  output  1  high while in ACCUM.
REQ-014 ovf  output  1  sticky saturation flag for the current/last run.

Function
REQ-015 FSM SHALL have states IDLE, ACCUM and DONE, encoded in registers.
REQ-016 IDLE: start=1 with len!=0 SHALL clear the accumulator and ovf, load the remaining-count register with len, and move to ACCUM.
REQ-017 IDLE or DONE: start=1 with len=0 SHALL clear the accumulator and ovf and move to DONE; sum_out=0 and sum_valid=1 on the next cycle.
REQ-018 diff_ready SHALL be 1 exactly when state=ACCUM; it SHALL be combinational from state only, never from diff_valid.
REQ-019 A transfer SHALL occur on any rising edge with diff_valid=1 and diff_ready=1; no other cycle changes the accumulator in ACCUM.
REQ-020 On transfer, acc_next SHALL equal acc + sign-extend(diff_in) computed in ACC_W+1 bits.
REQ-021 If acc_next > 2^(ACC_W-1)-1, acc SHALL load 2^(ACC_W-1)-1 and ovf SHALL set.
REQ-022 If acc_next < -2^(ACC_W-1), acc SHALL load -2^(ACC_W-1) and ovf SHALL set.
REQ-023 ovf SHALL stay set until the next accepted start or reset.
REQ-024 Each transfer SHALL decrement the remaining count; a transfer with remaining=1 SHALL move the FSM to DONE.
REQ-025 sum_valid SHALL be 1 exactly when state=DONE, asserting in the cycle after the final transfer (latency 1).
REQ-026 sum_out SHALL always drive the accumulator register; it is stable throughout DONE.
REQ-027 start asserted during ACCUM SHALL be ignored; len is not resampled.
REQ-028 DONE SHALL persist until start; start in DONE behaves as in IDLE (REQ-016/017), so back-to-back runs are possible with no idle cycle.
REQ-029 diff_valid gaps in ACCUM SHALL stall the run indefinitely without changing acc or count.
REQ-030 busy SHALL be 1 exactly when state=ACCUM.

Reset
REQ-031 rst_n=0 SHALL immediately force state=IDLE, acc=0, remaining=0, ovf=0, so that sum_out=0, sum_valid=0, diff_ready=0, busy=0.
REQ-032 Reset mid-run SHALL abandon the run; after release the block waits in IDLE for start.

Verification
REQ-033 start, len=3; diffs 100, -30, 5 on consecutive cycles -> sum_out=75, sum_valid=1 one cycle after the third transfer, busy=0, ovf=0.
REQ-034 start, len=4; diff_valid toggled 1,0,0,1,1,0,1 with diffs 10,20,30,40 on the valid cycles -> sum_out=100; only 4 transfers counted.
REQ-035 start, len=300, every diff=32767 -> sum_out saturates at 8388607, ovf=1, sum_valid after the 300th transfer.
REQ-036 start, len=300, every diff=-32768 -> sum_out=-8388608, ovf=1.
REQ-037 start, len=0 -> sum_out=0, sum_valid=1 the next cycle, diff_ready never asserted; then start with len=2 in DONE -> ovf cleared, new run begins.
REQ-038 rst_n pulsed low after 2 of 5 transfers -> all outputs 0 immediately; a subsequent start, len=1, diff=7 -> sum_out=7.
